// File: rtl/alu_pkg.sv
// Shared ALU issue types and the operand-forming function used by the operand stage.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_REG, IMM_SEXT, IMM_ZEXT, IMM_LUI
  } imm_mode_t;

  typedef struct packed {
    alu_op_t           op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } alu_in_pkt_t;

  function automatic alu_in_pkt_t form_operands(
    input alu_op_t           op,
    input logic [DATA_W-1:0] rs_val,
    input logic [DATA_W-1:0] rt_val,
    input logic [15:0]       imm,
    input logic [4:0]        shamt,
    input logic              a_sel,
    input imm_mode_t         b_sel
  );
    alu_in_pkt_t p;
    p.op  = op;
    p.opa = a_sel ? {{(DATA_W-5){1'b0}}, shamt} : rs_val;
    case (b_sel)
      IMM_SEXT: p.opb = {{(DATA_W-16){imm[15]}}, imm};
      IMM_ZEXT: p.opb = {{(DATA_W-16){1'b0}}, imm};
      IMM_LUI:  p.opb = {imm, {(DATA_W-16){1'b0}}};
      default:  p.opb = rt_val;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-to-stage and stage-to-ALU handshake bundle; slave is the operand stage.
interface alu_operand_stage_if;
  import alu_pkg::*;

  logic                     dec_valid;
  logic                     dec_ready;
  alu_op_t                  dec_op;
  logic [alu_pkg::DATA_W-1:0] dec_rs_val;
  logic [alu_pkg::DATA_W-1:0] dec_rt_val;
  logic [15:0]              dec_imm;
  logic [4:0]               dec_shamt;
  logic                     dec_a_sel;
  imm_mode_t                dec_b_sel;
  logic                     alu_in_valid;
  logic                     alu_in_ready;
  alu_in_pkt_t              alu_in_pkt;

  modport slave (
    input  dec_valid, dec_op, dec_rs_val, dec_rt_val, dec_imm, dec_shamt,
           dec_a_sel, dec_b_sel, alu_in_ready,
    output dec_ready, alu_in_valid, alu_in_pkt
  );

  modport master (
    output dec_valid, dec_op, dec_rs_val, dec_rt_val, dec_imm, dec_shamt,
           dec_a_sel, dec_b_sel, alu_in_ready,
    input  dec_ready, alu_in_valid, alu_in_pkt
  );

endinterface

// File: rtl/alu_operand_fifo.sv
// DEPTH x alu_in_pkt_t FIFO, registered write, combinational head read; flush empties it next cycle.
// Push when full and pop when empty are ignored; flush discards any push/pop in the same cycle.
module alu_operand_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  alu_in_pkt_t                wr_dat_i,
  input  logic                       pop_i,
  output alu_in_pkt_t                rd_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  alu_in_pkt_t mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head presents all-zero packets out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU issue stage: forms operands and buffers packets in a DEPTH FIFO (1-cycle latency, decode stalls only when full).
// ALU_OPERAND_BYPASS_EN: an empty FIFO with a ready ALU forwards the formed packet in the same cycle.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  alu_operand_stage_if.slave       bus,
  output logic [$clog2(DEPTH):0]   occupancy
);

  logic [DATA_W-1:0] rs_val, rt_val;
  alu_in_pkt_t       formed_pkt, head_pkt;
  logic              full, empty, push, pop, bypass;

  assign rs_val = bus.dec_rs_val;
  assign rt_val = bus.dec_rt_val;

  assign formed_pkt = form_operands(bus.dec_op, rs_val, rt_val, bus.dec_imm,
                                    bus.dec_shamt, bus.dec_a_sel, bus.dec_b_sel);

  // No pass-through when full: a pop does not free a slot for the same cycle's push.
  assign bus.dec_ready = !full && !flush;
  assign push          = bus.dec_valid && bus.dec_ready;
  assign pop           = !empty && bus.alu_in_ready;

`ifdef ALU_OPERAND_BYPASS_EN
  assign bypass = empty && bus.dec_valid && bus.alu_in_ready && !flush && resetn;
`else
  assign bypass = 1'b0;
`endif

  assign bus.alu_in_valid = !empty || bypass;
  assign bus.alu_in_pkt   = bypass ? formed_pkt : head_pkt;

  alu_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush_i  (flush),
    .push_i   (push && !bypass),
    .wr_dat_i (formed_pkt),
    .pop_i    (pop),
    .rd_dat_o (head_pkt),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (occupancy)
  );

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a packet scoreboard on the ALU side.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
`ifdef ALU_OPERAND_BYPASS_EN
  localparam logic [2:0] STREAM_OCC = 3'd0;
`else
  localparam logic [2:0] STREAM_OCC = 3'd1;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [2:0] occupancy;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  alu_in_pkt_t sb[$];
  alu_in_pkt_t exp_pkt;
  alu_in_pkt_t popped;
  bit          last_push;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic alu_in_pkt_t model(input alu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [15:0] imm, input logic [4:0] sh,
                                        input logic asel, input imm_mode_t bsel);
    logic [31:0] a, b;
    a = asel ? 32'(sh) : rs;
    case (bsel)
      IMM_SEXT: b = 32'($signed(imm));
      IMM_ZEXT: b = 32'(imm);
      IMM_LUI:  b = 32'(imm) << 16;
      default:  b = rt;
    endcase
    return {op, a, b};
  endfunction

  task automatic drive(input alu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [4:0] sh, input logic asel,
                       input imm_mode_t bsel, input alu_in_pkt_t exp);
    bus.dec_valid  = 1'b1;
    bus.dec_op     = op;
    bus.dec_rs_val = rs;
    bus.dec_rt_val = rt;
    bus.dec_imm    = imm;
    bus.dec_shamt  = sh;
    bus.dec_a_sel  = asel;
    bus.dec_b_sel  = bsel;
    exp_pkt        = exp;
  endtask

  task automatic drive_rand();
    alu_op_t     op;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        asel;
    imm_mode_t   bsel;
    op   = alu_op_t'(4'($urandom_range(0, 9)));
    rs   = $urandom;
    rt   = $urandom;
    imm  = 16'($urandom);
    sh   = 5'($urandom);
    asel = 1'($urandom);
    bsel = imm_mode_t'(2'($urandom_range(0, 3)));
    drive(op, rs, rt, imm, sh, asel, bsel, model(op, rs, rt, imm, sh, asel, bsel));
  endtask

  // Called at posedge+1; samples mid-cycle, then advances to the next posedge+1.
  task automatic step();
    #4;
    last_push = bus.dec_valid && bus.dec_ready;
    if (last_push) sb.push_back(exp_pkt);
    if (bus.alu_in_valid && bus.alu_in_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_spurious observed=%h expected=no_packet", bus.alu_in_pkt);
      end
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        check("sb_order", bus.alu_in_pkt, popped);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.dec_valid    = 1'b0;
    bus.alu_in_ready = 1'b1;
    for (int k = 0; k < 12 && sb.size() != 0; k++) step();
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
    check({tag, "_occ_zero"}, 128'(occupancy), 128'd0);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn           = 1'b0;
    flush            = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.alu_in_ready = 1'b0;
    bus.dec_op       = OP_ADD;
    bus.dec_rs_val   = '0;
    bus.dec_rt_val   = '0;
    bus.dec_imm      = '0;
    bus.dec_shamt    = '0;
    bus.dec_a_sel    = 1'b0;
    bus.dec_b_sel    = IMM_REG;
    exp_pkt          = '0;
    last_push        = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 128'(bus.alu_in_valid), 128'd0);
    check("rst_occ",   128'(occupancy),        128'd0);
    check("rst_pkt",   128'(bus.alu_in_pkt),   128'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_dec_ready", 128'(bus.dec_ready), 128'd1);

    // 1: SEXT immediate, one-cycle latency through the FIFO
    bus.alu_in_ready = 1'b1;
    drive(OP_ADD, 32'h10, 32'h0, 16'hFFFE, 5'd0, 1'b0, IMM_SEXT, {OP_ADD, 32'h10, 32'hFFFFFFFE});
    step();
    bus.dec_valid = 1'b0;
`ifndef ALU_OPERAND_BYPASS_EN
    check("t1_valid_n1", 128'(bus.alu_in_valid), 128'd1);
    check("t1_pkt_n1",   128'(bus.alu_in_pkt),   128'({OP_ADD, 32'h10, 32'hFFFFFFFE}));
    check("t1_occ_n1",   128'(occupancy),        128'd1);
`endif
    drain("t1");

    // 2: LUI, ZEXT and shamt-as-A
    drive(OP_OR,  32'h0, 32'h0, 16'h1234, 5'd0,  1'b0, IMM_LUI,  {OP_OR,  32'h0,  32'h12340000});
    step();
    drive(OP_AND, 32'h5, 32'h0, 16'h8000, 5'd0,  1'b0, IMM_ZEXT, {OP_AND, 32'h5,  32'h00008000});
    step();
    drive(OP_SLL, 32'hDEADBEEF, 32'h7, 16'h0, 5'd31, 1'b1, IMM_REG, {OP_SLL, 32'h1F, 32'h7});
    step();
    drain("t2");

    // 3: back-pressure with five pushes into a four-entry FIFO
    bus.alu_in_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_SUB, 32'(i) << 8, 32'(i), 16'h0, 5'd0, 1'b0, IMM_REG, {OP_SUB, 32'(i) << 8, 32'(i)});
      step();
    end
    drive(OP_XOR, 32'h400, 32'h4, 16'h0, 5'd0, 1'b0, IMM_REG, {OP_XOR, 32'h400, 32'h4});
    check("t3_occ_full",  128'(occupancy),     128'd4);
    check("t3_dec_ready", 128'(bus.dec_ready), 128'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3_stall_valid",  128'(bus.alu_in_valid), 128'd1);
      check("t3_stall_stable", 128'(bus.alu_in_pkt),   128'({OP_SUB, 32'h0, 32'h0}));
      check("t3_stall_ready",  128'(bus.dec_ready),    128'd0);
    end
    check("t3_held_sb", 128'(sb.size()), 128'd4);
    bus.alu_in_ready = 1'b1;
    for (int k = 0; k < 12 && (bus.dec_valid || sb.size() != 0); k++) begin
      step();
      if (last_push) bus.dec_valid = 1'b0;
    end
    check("t3_fifth_taken", 128'(bus.dec_valid), 128'd0);
    drain("t3");

    // 4: streaming, one packet per cycle across many pointer wraps
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      if (i > 0) begin
        check("t4_occ",   128'(occupancy),        128'(STREAM_OCC));
        check("t4_valid", 128'(bus.alu_in_valid), 128'd1);
      end
      step();
    end
    drain("t4");

    // 5: flush with three buffered plus a concurrent push
    bus.alu_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    check("t5_occ3", 128'(occupancy), 128'd3);
    drive_rand();
    flush = 1'b1;
    #2;
    check("t5_flush_dec_ready", 128'(bus.dec_ready), 128'd0);
    #2;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    bus.dec_valid = 1'b0;
    check("t5_valid_after", 128'(bus.alu_in_valid), 128'd0);
    check("t5_occ_after",   128'(occupancy),        128'd0);
    bus.alu_in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_emit", 128'(bus.alu_in_valid), 128'd0);
    end

    // 6: asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    #2;
    resetn        = 1'b0;
    bus.dec_valid = 1'b0;
    #1;
    check("t6_valid_rst", 128'(bus.alu_in_valid), 128'd0);
    check("t6_occ_rst",   128'(occupancy),        128'd0);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    drive(OP_SLT, 32'h77, 32'h0, 16'h0001, 5'd0, 1'b0, IMM_SEXT, {OP_SLT, 32'h77, 32'h1});
    step();
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
